// File: rtl/proc_elem_dm.sv
// proc_elem_dm -- second-generation systolic-array processing element.
// Independent activation / weight / accumulator widths, double-buffered
// weights and a runtime choice between weight-stationary (mode = 0) and
// output-stationary (mode = 1) dataflow. Activations travel east, weights
// and partial sums travel south; every datapath output is registered.
// Optional build macro PROC_ELEM_DM_SAT_EN: accumulate results saturate
// instead of wrapping, and a registered sat_flag output marks clipped cycles.
// ACC_WIDTH must be at least DATA_WIDTH + WEIGHT_WIDTH.
module proc_elem_dm #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_val,
  input  logic [WEIGHT_WIDTH-1:0] in_weight,
  input  logic [ACC_WIDTH-1:0]    in_sum,
  input  logic                    w_shift,
  input  logic                    w_swap,
  input  logic                    acc_clear,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_val,
  output logic [WEIGHT_WIDTH-1:0] out_weight,
`ifdef PROC_ELEM_DM_SAT_EN
  output logic                    sat_flag,
`endif
  output logic [ACC_WIDTH-1:0]    out_sum
);

  localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
`ifdef PROC_ELEM_DM_SAT_EN
  // One guard bit above the accumulator width exposes signed overflow.
  localparam int SUM_WIDTH = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`else
  // Wrapping arithmetic: the sum is simply kept at accumulator width.
  localparam int SUM_WIDTH = ACC_WIDTH;
`endif

  // Registered mode; a mismatch with the live input marks a switch cycle.
  logic                           mode_q;
  logic                           mode_switch;

  // Double-buffered weight: shadow is loaded by the chain, active feeds the MAC.
  logic signed [WEIGHT_WIDTH-1:0] shadow_w;
  logic signed [WEIGHT_WIDTH-1:0] active_w;

  // Output-stationary accumulator.
  logic signed [ACC_WIDTH-1:0]    acc;

  // Datapath intermediates.
  logic signed [PROD_WIDTH-1:0]   ws_prod;
  logic signed [PROD_WIDTH-1:0]   os_prod;
  logic signed [SUM_WIDTH-1:0]    ws_sum;
  logic signed [SUM_WIDTH-1:0]    os_sum;
  logic signed [ACC_WIDTH-1:0]    ws_res;
  logic signed [ACC_WIDTH-1:0]    os_res;
  logic signed [ACC_WIDTH-1:0]    os_base;
  logic signed [ACC_WIDTH-1:0]    acc_next;
`ifdef PROC_ELEM_DM_SAT_EN
  logic                           ws_clip;
  logic                           os_clip;
`endif

  assign mode_switch = (mode != mode_q);

  // MAC arithmetic for both modes: full-width signed products, sign-extended sums.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // a value unassigned and infer a latch.
    ws_prod  = PROD_WIDTH'($signed(in_val)) * PROD_WIDTH'(active_w);
    os_prod  = PROD_WIDTH'($signed(in_val)) * PROD_WIDTH'($signed(in_weight));
    ws_sum   = SUM_WIDTH'($signed(in_sum)) + SUM_WIDTH'(ws_prod);
    // A clear restarts the dot product from this cycle's product (or from 0).
    os_base  = acc_clear ? '0 : acc;
    os_sum   = SUM_WIDTH'(os_base) + SUM_WIDTH'(os_prod);
    ws_res   = ws_sum[ACC_WIDTH-1:0];
    os_res   = os_sum[ACC_WIDTH-1:0];
`ifdef PROC_ELEM_DM_SAT_EN
    // Top two bits disagree only when the true sum left the accumulator range.
    ws_clip  = ws_sum[SUM_WIDTH-1] ^ ws_sum[SUM_WIDTH-2];
    os_clip  = os_sum[SUM_WIDTH-1] ^ os_sum[SUM_WIDTH-2];
    if (ws_clip) ws_res = ws_sum[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
    if (os_clip) os_res = os_sum[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
`endif
    // Without a valid input the accumulator holds (or clears on acc_clear).
    acc_next = in_valid ? os_res : os_base;
  end

  // State and output registers: mode tracking, weight buffers, accumulator, outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= 1'b0;
      shadow_w   <= '0;
      active_w   <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_val    <= '0;
      out_weight <= '0;
      out_sum    <= '0;
`ifdef PROC_ELEM_DM_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      mode_q <= mode;
`ifdef PROC_ELEM_DM_SAT_EN
      sat_flag <= 1'b0;
`endif
      if (mode_switch) begin
        // Switch cycle: flush the accumulator and drop this cycle's input.
        acc       <= '0;
        out_sum   <= '0;
        out_valid <= 1'b0;
      end else if (!mode_q) begin
        // Weight-stationary: add this PE's product to the partial sum from north.
        out_valid <= in_valid;
        if (in_valid) begin
          out_sum <= ws_res;
          out_val <= in_val;
`ifdef PROC_ELEM_DM_SAT_EN
          sat_flag <= ws_clip;
`endif
        end
        // NOTE: non-blocking assignments make a same-cycle swap read the shadow
        // value from before this cycle's shift, and the MAC above read the old
        // active weight.
        if (w_shift) begin
          out_weight <= shadow_w;
          shadow_w   <= $signed(in_weight);
        end
        if (w_swap) begin
          active_w <= shadow_w;
        end
      end else begin
        // Output-stationary: weights stream through, the sum stays in this PE.
        out_valid <= in_valid;
        acc       <= acc_next;
        out_sum   <= acc_next;
        if (in_valid) begin
          out_val    <= in_val;
          out_weight <= in_weight;
`ifdef PROC_ELEM_DM_SAT_EN
          sat_flag   <= os_clip;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_elem_dm.sv
// tb_proc_elem_dm -- directed and randomized bench for proc_elem_dm with a
// behavioural reference model built from integer arithmetic.
// Honours PROC_ELEM_DM_SAT_EN the same way as the design.
module tb_proc_elem_dm;

  localparam int    ACC_W   = 24;
  localparam longint MODV   = 64'sd1 << ACC_W;
  localparam longint ACC_MX = (64'sd1 << (ACC_W - 1)) - 1;
  localparam longint ACC_MN = -(64'sd1 << (ACC_W - 1));

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        in_valid;
  logic [7:0]  in_val;
  logic [7:0]  in_weight;
  logic [23:0] in_sum;
  logic        w_shift;
  logic        w_swap;
  logic        acc_clear;
  logic        out_valid;
  logic [7:0]  out_val;
  logic [7:0]  out_weight;
  logic [23:0] out_sum;
`ifdef PROC_ELEM_DM_SAT_EN
  logic        sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit     m_mode_q;
  int     m_shadow, m_active;
  longint m_acc;
  bit     m_ov;
  int     m_oval, m_ow;
  longint m_osum;
  bit     m_sat;

  proc_elem_dm dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_val     (in_val),
    .in_weight  (in_weight),
    .in_sum     (in_sum),
    .w_shift    (w_shift),
    .w_swap     (w_swap),
    .acc_clear  (acc_clear),
    .out_valid  (out_valid),
    .out_val    (out_val),
    .out_weight (out_weight),
`ifdef PROC_ELEM_DM_SAT_EN
    .sat_flag   (sat_flag),
`endif
    .out_sum    (out_sum)
  );

  always #5 clk = ~clk;

  // Map an exact integer result onto the accumulator range.
  function automatic longint fit(input longint v, output bit clip);
    longint u;
`ifdef PROC_ELEM_DM_SAT_EN
    clip = 1'b0;
    u = v;
    if (v > ACC_MX) begin clip = 1'b1; u = ACC_MX; end
    if (v < ACC_MN) begin clip = 1'b1; u = ACC_MN; end
`else
    clip = 1'b0;
    u = v % MODV;
    if (u < 0) u = u + MODV;
    if (u > ACC_MX) u = u - MODV;
`endif
    return u;
  endfunction

  task automatic model_reset();
    m_mode_q = 0; m_shadow = 0; m_active = 0; m_acc = 0;
    m_ov = 0; m_oval = 0; m_ow = 0; m_osum = 0; m_sat = 0;
  endtask

  // One clock of PE behaviour computed from the current inputs.
  task automatic model_step();
    int     v = int'($signed(in_val));
    int     w = int'($signed(in_weight));
    longint s = longint'($signed(in_sum));
    bit     clip;
    longint r;
    m_sat = 0;
    if (mode != m_mode_q) begin
      m_acc = 0; m_osum = 0; m_ov = 0;
    end else if (!m_mode_q) begin
      m_ov = in_valid;
      if (in_valid) begin
        r = fit(s + longint'(v * m_active), clip);
        m_osum = r; m_oval = v; m_sat = clip;
      end
      if (w_swap) m_active = m_shadow;
      if (w_shift) begin m_ow = m_shadow; m_shadow = w; end
    end else begin
      m_ov = in_valid;
      if (in_valid) begin
        r = fit((acc_clear ? 0 : m_acc) + longint'(v * w), clip);
        m_acc = r; m_oval = v; m_ow = w; m_sat = clip;
      end else if (acc_clear) begin
        m_acc = 0;
      end
      m_osum = m_acc;
    end
    m_mode_q = mode;
  endtask

  task automatic check(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".out_valid"},  longint'(out_valid),          longint'(m_ov));
    check({tag, ".out_val"},    longint'($signed(out_val)),    longint'(m_oval));
    check({tag, ".out_weight"}, longint'($signed(out_weight)), longint'(m_ow));
    check({tag, ".out_sum"},    longint'($signed(out_sum)),    m_osum);
`ifdef PROC_ELEM_DM_SAT_EN
    check({tag, ".sat_flag"},   longint'(sat_flag),           longint'(m_sat));
`endif
  endtask

  task automatic drive(input bit md, input bit vld, input int v, input int w,
                       input int s, input bit sh, input bit sw, input bit clr);
    mode = md; in_valid = vld; in_val = 8'(v); in_weight = 8'(w);
    in_sum = 24'(s); w_shift = sh; w_swap = sw; acc_clear = clr;
  endtask

  // Advance one clock, update the model, then compare just after the edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outs(tag);
  endtask

  initial begin
    // ---- reset state ----
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_outs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // ---- WS load / swap ----
    drive(0, 0, 0, 5, 0, 1, 0, 0);    cycle("ws_c0");
    drive(0, 0, 0, -2, 0, 1, 1, 0);   cycle("ws_c1");
    check("ws_c1_weight", longint'($signed(out_weight)), 5);
    drive(0, 1, 3, 0, 10, 0, 0, 0);   cycle("ws_c2");
    check("ws_mac_sum", longint'($signed(out_sum)), 25);
    check("ws_mac_val", longint'($signed(out_val)), 3);
    check("ws_mac_weight", longint'($signed(out_weight)), 5);
    drive(0, 0, 0, 0, 0, 0, 1, 0);    cycle("ws_c3");
    drive(0, 1, 3, 0, 0, 0, 0, 0);    cycle("ws_c4");
    check("ws_swap_sum", longint'($signed(out_sum)), -6);

    // ---- simultaneous shift + swap ----
    drive(0, 0, 0, 7, 0, 1, 0, 0);    cycle("sim_load7");
    drive(0, 0, 0, 9, 0, 1, 1, 0);    cycle("sim_shswap");
    check("sim_out_weight", longint'($signed(out_weight)), 7);
    drive(0, 1, 1, 0, 0, 0, 0, 0);    cycle("sim_mac");
    check("sim_active7", longint'($signed(out_sum)), 7);
    drive(0, 0, 0, 0, 0, 1, 0, 0);    cycle("sim_shadow9");
    check("sim_shadow_out", longint'($signed(out_weight)), 9);

    // ---- WS overflow ----
    drive(0, 0, 0, 127, 0, 1, 0, 0);  cycle("ovf_load");
    drive(0, 0, 0, 0, 0, 1, 1, 0);    cycle("ovf_swap");
    drive(0, 1, 127, 0, 8388600, 0, 0, 0); cycle("ovf_mac");
`ifdef PROC_ELEM_DM_SAT_EN
    check("ovf_sum", longint'($signed(out_sum)), 8388607);
    check("ovf_flag", longint'(sat_flag), 1);
`else
    check("ovf_sum", longint'($signed(out_sum)), -8372487);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0);    cycle("ovf_idle");
`ifdef PROC_ELEM_DM_SAT_EN
    check("ovf_flag_clear", longint'(sat_flag), 0);
`endif

    // ---- OS accumulate and restart ----
    drive(1, 0, 0, 0, 0, 0, 0, 0);    cycle("os_switch");
    check("os_switch_sum", longint'($signed(out_sum)), 0);
    drive(1, 1, 2, 3, 0, 0, 0, 0);    cycle("os_p1");
    check("os_sum1", longint'($signed(out_sum)), 6);
    drive(1, 1, -4, 5, 0, 0, 0, 0);   cycle("os_p2");
    check("os_sum2", longint'($signed(out_sum)), -14);
    drive(1, 1, 6, 7, 0, 0, 0, 0);    cycle("os_p3");
    check("os_sum3", longint'($signed(out_sum)), 28);
    drive(1, 1, 1, 1, 0, 1, 1, 1);    cycle("os_restart");
    check("os_restart_sum", longint'($signed(out_sum)), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);    cycle("os_hold");
    check("os_hold_sum", longint'($signed(out_sum)), 1);
    check("os_hold_valid", longint'(out_valid), 0);

    // ---- asynchronous reset mid-run ----
    drive(1, 1, 20, 25, 0, 0, 0, 1);  cycle("rst_pre");
    check("rst_pre_sum", longint'($signed(out_sum)), 500);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outs("rst_async");
    @(posedge clk);
    #1 reset = 1'b0;
    cycle("rst_switch");
    drive(1, 1, 3, 4, 0, 0, 0, 0);    cycle("rst_first");
    check("rst_first_sum", longint'($signed(out_sum)), 12);

    // ---- mode switch OS -> WS drops the input ----
    drive(1, 1, 5, 8, 0, 0, 0, 1);    cycle("ms_acc40");
    check("ms_acc40_sum", longint'($signed(out_sum)), 40);
    drive(0, 1, 9, 0, 3, 0, 0, 0);    cycle("ms_switch");
    check("ms_switch_sum", longint'($signed(out_sum)), 0);
    check("ms_switch_valid", longint'(out_valid), 0);
    drive(0, 1, 9, 0, 3, 0, 0, 0);    cycle("ms_ws_mac");

    // ---- randomized traffic ----
    for (int i = 0; i < 400; i++) begin
      bit md = mode;
      if ($urandom_range(0, 31) == 0) md = ~md;
      drive(md, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_elem_dm.md
Name: proc_elem_dm

Overview:
- Second-generation systolic-array processing element, generalised beyond the fixed-width weight-stationary PE.
- Independent activation, weight and accumulator widths.
- Double-buffered weights, so the next weight loads while the current one computes.
- Valid-qualified dataflow; runtime choice of weight-stationary (WS) or output-stationary (OS) mode.
- Tiles into an R x C grid: activations flow east, weights and partial sums flow south.

Parameters:
DATA_WIDTH, 8, signed activation width
WEIGHT_WIDTH, 8, signed weight width
ACC_WIDTH, 24, signed accumulator / partial-sum width; must be >= DATA_WIDTH+WEIGHT_WIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
mode  in  1  0 = WS, 1 = OS
in_valid  in  1  in_val / in_sum (WS) or in_val / in_weight (OS) valid this cycle
in_val  in  DATA_WIDTH  signed activation from west
in_weight  in  WEIGHT_WIDTH  signed weight from north
in_sum  in  ACC_WIDTH  signed partial sum from north (WS only)
w_shift  in  1  WS: shift in_weight into the shadow register
w_swap  in  1  WS: copy shadow weight to active weight
acc_clear  in  1  OS: restart accumulation
out_valid  out  1  registered copy of in_valid
out_val  out  DATA_WIDTH  activation to east
out_weight  out  WEIGHT_WIDTH  weight to south
out_sum  out  ACC_WIDTH  partial sum (WS) or accumulator (OS) to south

Behaviour:
- Reset: all outputs, shadow/active weights, accumulator and mode_q go to 0 immediately on reset assertion, mid-operation included; no pending state survives.
- Arithmetic:
  - product = in_val * weight, full DATA_WIDTH+WEIGHT_WIDTH signed.
  - product is sign-extended to ACC_WIDTH.
  - Sums wrap modulo 2^ACC_WIDTH by default.
- Latency: every datapath output is registered, 1 cycle after the input.
- mode_q <= mode every cycle. On a cycle where mode != mode_q:
  - accumulator <= 0, out_sum <= 0, out_valid <= 0.
  - in_valid is ignored that cycle; the new mode takes effect the next cycle.
- WS mode (mode_q = 0):
  - in_valid = 1: out_sum <= in_sum + in_val*active_w; out_val <= in_val; out_valid <= 1.
  - in_valid = 0: out_valid <= 0; out_val and out_sum hold.
  - w_shift = 1: out_weight <= shadow_w and shadow_w <= in_weight. Chaining out_weight south loads one PE per cycle.
  - w_swap = 1: active_w <= shadow_w, using the shadow value before any same-cycle w_shift update. The swap takes effect for the next cycle's MAC; a MAC in the same cycle still uses the old active_w.
  - w_shift and w_swap operate independently of in_valid.
- OS mode (mode_q = 1):
  - Weight is streamed, not stored. w_shift and w_swap are ignored; shadow_w and active_w hold.
  - in_valid = 1: acc <= acc + in_val*in_weight; out_val <= in_val; out_weight <= in_weight; out_valid <= 1.
  - acc_clear = 1 with in_valid = 1: acc <= in_val*in_weight, so a new dot product starts with no bubble.
  - acc_clear = 1 with in_valid = 0: acc <= 0.
  - in_valid = 0 and acc_clear = 0: acc, out_val and out_weight hold; out_valid <= 0.
  - out_sum <= next acc value every cycle; in_sum is ignored.
  - acc_clear is ignored in WS mode.
- Overflow: wraps (two's complement) unless the optional feature below is enabled.

Optional Feature:
- Macro: PROC_ELEM_DM_SAT_EN.
- Defined:
  - Every accumulate result (WS sum and OS acc) saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Adds output sat_flag (1 bit): registered, 1 for each cycle whose result clipped; reset 0.
- Undefined: wrap-around; no sat_flag port.

Test Plan (defaults 8/8/24):
- Reset mid-run: OS acc = 500, assert reset -> all outputs 0 the same cycle (async); after deassert, the first valid 3*4 gives out_sum = 12.
- WS load/swap:
  - Cycle 0: w_shift with in_weight = 5.
  - Cycle 1: w_swap, plus w_shift with in_weight = -2.
  - Cycle 2: in_valid, in_val = 3, in_sum = 10 -> cycle 3 out_sum = 25, out_val = 3, out_weight = 5.
  - Cycle 3: w_swap, then valid in_val = 3, in_sum = 0 -> out_sum = -6.
- Simultaneous shift + swap: shadow = 7, w_shift(in_weight = 9) + w_swap in the same cycle -> active = 7, shadow = 9, out_weight = 7.
- OS accumulate and restart:
  - Valid pairs (2,3), (-4,5), (6,7) -> out_sum 6, -14, 28.
  - Then acc_clear + valid (1,1) -> out_sum 1, no zero bubble.
  - Then in_valid = 0 -> out_sum holds 1, out_valid = 0.
- Mode switch: OS acc = 40, mode -> 0 with in_valid = 1 -> next cycle out_sum = 0, out_valid = 0 (input dropped); the following WS valid computes normally.
- Overflow: WS in_sum = 8388600, in_val = 127, active_w = 127 -> without macro out_sum = -8372487 (wrap); with PROC_ELEM_DM_SAT_EN out_sum = 8388607, sat_flag = 1 for one cycle.
